vc_egress_sched: RTL and testbench

- Weighted round-robin scheduler for the two virtual-channel FIFOs (VC0, VC1) of the PCIe transaction layer. It sits between the FIFO bank and a single shared egress lane.
- Decides which VC is popped each cycle and honours downstream pause (backpressure).
- Steers the popped word onto one registered egress bus.
- Replaces per-port fixed popping with a configurable bandwidth share.

---
 rtl/vc_egress_sched_pkg.sv | 20 ++
 rtl/vc_egress_mux.sv | 47 ++++
 rtl/vc_egress_sched.sv | 188 ++++++++++++++++++
 tb/tb_vc_egress_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_egress_sched_pkg.sv
// Shared types and constants for the two-VC weighted round-robin egress scheduler.
package vc_egress_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SERVE0 = 2'b01,
    ST_SERVE1 = 2'b10
  } state_e;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  localparam int unsigned DEFAULT_WEIGHT = 1;

  // SERVE state that owns the given VC
  function automatic state_e serve_state(input logic vc);
    return (vc == VC1) ? ST_SERVE1 : ST_SERVE0;
  endfunction

endpackage

// File: rtl/vc_egress_mux.sv
// Egress datapath: delays the pop selector by one cycle (FIFO read latency) and
// registers the steered word; data_out holds when nothing valid arrives.
module vc_egress_mux
  import vc_egress_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              pop_sel,
  input  logic [DATA_W-1:0] data_vc0,
  input  logic [DATA_W-1:0] data_vc1,
  input  logic              valid_vc0,
  input  logic              valid_vc1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out
);

  logic              sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    sel_d   = pop_sel;
    valid_d = (sel_q == VC1) ? valid_vc1 : valid_vc0;
    data_d  = data_q;
    if (valid_d) begin
      data_d = (sel_q == VC1) ? data_vc1 : data_vc0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_q   <= VC0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/vc_egress_sched.sv
// Weighted round-robin scheduler popping two VC FIFOs onto one egress lane.
// Optional per-VC pop counters are built when VC_SCHED_STATS_EN is defined.
module vc_egress_sched
  import vc_egress_sched_pkg::*;
#(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned WEIGHT_W = 3
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] weight_vc0,
  input  logic [WEIGHT_W-1:0] weight_vc1,
  input  logic                empty_vc0,
  input  logic                empty_vc1,
  input  logic [DATA_W-1:0]   data_vc0,
  input  logic [DATA_W-1:0]   data_vc1,
  input  logic                valid_vc0,
  input  logic                valid_vc1,
  input  logic                pause_out,
  output logic                pop_vc0,
  output logic                pop_vc1,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  output logic                grant_vc,
  output logic                idle
`ifdef VC_SCHED_STATS_EN
  ,
  output logic [7:0]          grant_cnt_vc0,
  output logic [7:0]          grant_cnt_vc1
`endif
);

  state_e              state_q, state_d;
  logic [WEIGHT_W-1:0] w0_q, w0_d, w1_q, w1_d;
  logic [WEIGHT_W-1:0] budget_q, budget_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                grant_q, grant_d;
  logic                idle_q, idle_d;
  logic                popped_q, popped_d;

  logic                pop0_c, pop1_c, pop_any_c;
  logic                cur_c, cur_empty_c, oth_empty_c;
  logic                start_c, nxt_c;
  logic [WEIGHT_W:0]   cnt_inc_c;

  // Pops come straight from the registered state so the FIFO sees them this cycle
  always_comb begin
    pop0_c      = (state_q == ST_SERVE0) && !empty_vc0 && !pause_out;
    pop1_c      = (state_q == ST_SERVE1) && !empty_vc1 && !pause_out;
    pop_any_c   = pop0_c || pop1_c;
    cur_c       = (state_q == ST_SERVE1);
    cur_empty_c = cur_c ? empty_vc1 : empty_vc0;
    oth_empty_c = cur_c ? empty_vc0 : empty_vc1;
    cnt_inc_c   = {1'b0, cnt_q} + {{WEIGHT_W{1'b0}}, pop_any_c};
  end

  // A zero weight would starve its VC, so it is stored as the default weight
  always_comb begin
    w0_d = w0_q;
    w1_d = w1_q;
    if (init) begin
      w0_d = (weight_vc0 == '0) ? WEIGHT_W'(DEFAULT_WEIGHT) : weight_vc0;
      w1_d = (weight_vc1 == '0) ? WEIGHT_W'(DEFAULT_WEIGHT) : weight_vc1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    budget_d = budget_q;
    last_d   = last_q;
    start_c  = 1'b0;
    nxt_c    = VC0;
    case (state_q)
      ST_IDLE: begin
        if (!pause_out && !(empty_vc0 && empty_vc1)) begin
          start_c = 1'b1;
          nxt_c   = empty_vc0 ? VC1 : (empty_vc1 ? VC0 : ~last_q);
        end
      end
      ST_SERVE0, ST_SERVE1: begin
        cnt_d = cnt_inc_c[WEIGHT_W-1:0];
        if (cur_empty_c || (cnt_inc_c == {1'b0, budget_q})) begin
          last_d = cur_c;
          cnt_d  = '0;
          if (!oth_empty_c) begin
            start_c = 1'b1;
            nxt_c   = ~cur_c;
          end else if (!cur_empty_c) begin
            start_c = 1'b1;
            nxt_c   = cur_c;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Budget is sampled only at a turn start so weight updates never cut a burst
    if (start_c) begin
      state_d  = serve_state(nxt_c);
      budget_d = (nxt_c == VC1) ? w1_q : w0_q;
      cnt_d    = '0;
    end
  end

  always_comb begin
    grant_d = grant_q;
    if (state_d == ST_SERVE0) grant_d = VC0;
    if (state_d == ST_SERVE1) grant_d = VC1;
    popped_d = pop_any_c;
    idle_d   = (state_d == ST_IDLE) && !pop_any_c && !popped_q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= ST_IDLE;
      w0_q     <= WEIGHT_W'(DEFAULT_WEIGHT);
      w1_q     <= WEIGHT_W'(DEFAULT_WEIGHT);
      budget_q <= WEIGHT_W'(DEFAULT_WEIGHT);
      cnt_q    <= '0;
      last_q   <= VC1;
      grant_q  <= VC0;
      idle_q   <= 1'b1;
      popped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      budget_q <= budget_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      idle_q   <= idle_d;
      popped_q <= popped_d;
    end
  end

  assign pop_vc0  = pop0_c;
  assign pop_vc1  = pop1_c;
  assign grant_vc = grant_q;
  assign idle     = idle_q;

  vc_egress_mux #(.DATA_W(DATA_W)) u_mux (
    .clk      (clk),
    .reset_L  (reset_L),
    .pop_sel  (pop1_c),
    .data_vc0 (data_vc0),
    .data_vc1 (data_vc1),
    .valid_vc0(valid_vc0),
    .valid_vc1(valid_vc1),
    .data_out (data_out),
    .valid_out(valid_out)
  );

`ifdef VC_SCHED_STATS_EN
  logic [7:0] gc0_q, gc0_d, gc1_q, gc1_d;

  // Saturating pop counters, cleared by a weight load
  always_comb begin
    gc0_d = gc0_q;
    gc1_d = gc1_q;
    if (init) begin
      gc0_d = '0;
      gc1_d = '0;
    end else begin
      if (pop0_c && (gc0_q != 8'hFF)) gc0_d = gc0_q + 8'd1;
      if (pop1_c && (gc1_q != 8'hFF)) gc1_d = gc1_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      gc0_q <= '0;
      gc1_q <= '0;
    end else begin
      gc0_q <= gc0_d;
      gc1_q <= gc1_d;
    end
  end

  assign grant_cnt_vc0 = gc0_q;
  assign grant_cnt_vc1 = gc1_q;
`endif

endmodule

// File: tb/tb_vc_egress_sched.sv
// Self-checking bench for vc_egress_sched: FIFO environment plus turn-level reference model.
module tb_vc_egress_sched;

  localparam int unsigned DW = 4;
  localparam int unsigned WW = 3;

  logic          clk = 1'b0;
  logic          reset_L, init, pause_out;
  logic [WW-1:0] weight_vc0, weight_vc1;
  logic          empty_vc0, empty_vc1, valid_vc0, valid_vc1;
  logic [DW-1:0] data_vc0, data_vc1;
  logic          pop_vc0, pop_vc1, valid_out, grant_vc, idle;
  logic [DW-1:0] data_out;
`ifdef VC_SCHED_STATS_EN
  logic [7:0]    grant_cnt_vc0, grant_cnt_vc1;
`endif

  always #5 clk = ~clk;

  vc_egress_sched #(.DATA_W(DW), .WEIGHT_W(WW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .weight_vc0(weight_vc0), .weight_vc1(weight_vc1),
    .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
    .data_vc0(data_vc0), .data_vc1(data_vc1),
    .valid_vc0(valid_vc0), .valid_vc1(valid_vc1),
    .pause_out(pause_out), .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .data_out(data_out), .valid_out(valid_out), .grant_vc(grant_vc), .idle(idle)
`ifdef VC_SCHED_STATS_EN
    , .grant_cnt_vc0(grant_cnt_vc0), .grant_cnt_vc1(grant_cnt_vc1)
`endif
  );

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Reference model: turn owner (-1 = none), pops used in the turn, turn budget
  int            m_owner, m_used, m_budget, m_last, m_prev_pop;
  int            m_w[2];
  logic          m_grant, m_idle, m_vout, m_d1_v;
  logic [DW-1:0] m_dout, m_d1_w;
`ifdef VC_SCHED_STATS_EN
  int            m_cnt[2];
`endif

  logic [8:0]    obs, expv;
  int            rec_pop[$];
  int            rec_trace[$];
  logic [DW-1:0] rec_data[$];

  task automatic model_reset();
    m_owner = -1; m_used = 0; m_budget = 1; m_last = 1; m_prev_pop = -1;
    m_w[0] = 1; m_w[1] = 1;
    m_grant = 1'b0; m_idle = 1'b1; m_vout = 1'b0; m_dout = '0;
    m_d1_v = 1'b0; m_d1_w = '0;
`ifdef VC_SCHED_STATS_EN
    m_cnt[0] = 0; m_cnt[1] = 0;
`endif
  endtask

  task automatic m_start(input int v);
    m_owner = v; m_used = 0; m_budget = m_w[v];
  endtask

  task automatic clear_rec();
    rec_pop.delete(); rec_trace.delete(); rec_data.delete();
  endtask

  task automatic push(input int vc, input logic [DW-1:0] w);
    if (vc == 0) begin q0.push_back(w); empty_vc0 = 1'b0; end
    else begin q1.push_back(w); empty_vc1 = 1'b0; end
  endtask

  // One clock: sample DUT vs model at negedge, advance model and FIFOs after posedge
  task automatic step();
    int   p, nxt;
    bit   e[2];
    bit   pz, ini, dp0, dp1;
    int   wv[2];
    @(negedge clk);
    step_no++;
    e[0] = empty_vc0; e[1] = empty_vc1; pz = pause_out; ini = init;
    wv[0] = int'(weight_vc0); wv[1] = int'(weight_vc1);
    p = -1;
    if (m_owner >= 0 && !e[m_owner] && !pz) p = m_owner;
    dp0 = pop_vc0; dp1 = pop_vc1;
    obs  = {pop_vc1, pop_vc0, valid_out, data_out, grant_vc, idle};
    expv = {p == 1, p == 0, m_vout, m_dout, m_grant, m_idle};
    rec_trace.push_back(dp0 ? 0 : (dp1 ? 1 : -1));
    if (dp0) rec_pop.push_back(0);
    if (dp1) rec_pop.push_back(1);
    if (valid_out) rec_data.push_back(data_out);

    m_vout = m_d1_v;
    if (m_d1_v) m_dout = m_d1_w;
    m_d1_v = (p >= 0);
    if (p == 0 && q0.size() > 0) m_d1_w = q0[0];
    if (p == 1 && q1.size() > 0) m_d1_w = q1[0];
`ifdef VC_SCHED_STATS_EN
    if (ini) begin m_cnt[0] = 0; m_cnt[1] = 0; end
    else if (p >= 0 && m_cnt[p] < 255) m_cnt[p]++;
`endif
    if (p >= 0) m_used++;
    if (m_owner < 0) begin
      if (!pz && !(e[0] && e[1])) begin
        nxt = e[1] ? 0 : (e[0] ? 1 : 1 - m_last);
        m_start(nxt);
      end
    end else if (e[m_owner] || m_used == m_budget) begin
      m_last = m_owner;
      if (!e[1 - m_owner]) m_start(1 - m_owner);
      else if (!e[m_owner]) m_start(m_owner);
      else m_owner = -1;
    end
    if (ini) for (int v = 0; v < 2; v++) m_w[v] = (wv[v] == 0) ? 1 : wv[v];
    if (m_owner >= 0) m_grant = (m_owner == 1);
    m_idle = (m_owner < 0) && (p < 0) && (m_prev_pop < 0);
    m_prev_pop = p;

    @(posedge clk);
    #1;
    valid_vc0 = dp0;
    valid_vc1 = dp1;
    if (dp0 && q0.size() > 0) data_vc0 = q0.pop_front();
    if (dp1 && q1.size() > 0) data_vc1 = q1.pop_front();
    empty_vc0 = (q0.size() == 0);
    empty_vc1 = (q1.size() == 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_L = 1'b0; init = 1'b0; pause_out = 1'b0;
    q0.delete(); q1.delete();
    empty_vc0 = 1'b1; empty_vc1 = 1'b1;
    @(posedge clk); #1;
    valid_vc0 = 1'b0; valid_vc1 = 1'b0;
    @(posedge clk); #1;
    reset_L = 1'b1;
    model_reset();
    clear_rec();
  endtask

  task automatic load_weights(input logic [WW-1:0] a, input logic [WW-1:0] b);
    init = 1'b1; weight_vc0 = a; weight_vc1 = b;
    step(); checks++;
    if (obs !== expv) begin errors++; $display("FAIL init_step %0d got %b exp %b", step_no, obs, expv); end
    init = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (pop_vc0 !== 1'b0)   begin errors++; $display("FAIL rst_pop0 got %b exp 0", pop_vc0); end
    if (pop_vc1 !== 1'b0)   begin errors++; $display("FAIL rst_pop1 got %b exp 0", pop_vc1); end
    if (data_out !== '0)    begin errors++; $display("FAIL rst_data got %h exp 0", data_out); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_out); end
    if (grant_vc !== 1'b0)  begin errors++; $display("FAIL rst_grant got %b exp 0", grant_vc); end
    if (idle !== 1'b1)      begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
    reset_L = 1'b1;
    model_reset();
  endtask

  task automatic test_wrr_2_1();
    int            eo[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    logic [DW-1:0] ed[12] = '{4'd0, 4'd1, 4'd8, 4'd2, 4'd3, 4'd9, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12, 4'd13};
    apply_reset();
    load_weights(3'd2, 3'd1);
    for (int i = 0; i < 6; i++) begin push(0, DW'(i)); push(1, DW'(8 + i)); end
    repeat (20) begin
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL wrr_step %0d got %b exp %b", step_no, obs, expv); end
    end
    checks += 2;
    if (rec_pop.size() != 12) begin errors++; $display("FAIL wrr_pop_count got %0d exp 12", rec_pop.size()); end
    if (rec_data.size() != 12) begin errors++; $display("FAIL wrr_data_count got %0d exp 12", rec_data.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i < rec_pop.size()) begin
        checks++;
        if (rec_pop[i] != eo[i]) begin errors++; $display("FAIL wrr_order[%0d] got %0d exp %0d", i, rec_pop[i], eo[i]); end
      end
      if (i < rec_data.size()) begin
        checks++;
        if (rec_data[i] !== ed[i]) begin errors++; $display("FAIL wrr_data[%0d] got %h exp %h", i, rec_data[i], ed[i]); end
      end
    end
  endtask

  task automatic test_vc1_only();
    apply_reset();
    for (int i = 0; i < 3; i++) push(1, DW'(5 + i));
    repeat (8) begin
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL vc1_step %0d got %b exp %b", step_no, obs, expv); end
    end
    checks += 3;
    if (rec_pop.size() != 3) begin errors++; $display("FAIL vc1_pop_count got %0d exp 3", rec_pop.size()); end
    // trace: step1 IDLE decision, steps 2-4 back-to-back pops, then no more pops
    if (rec_trace.size() < 5 || rec_trace[1] != 1 || rec_trace[2] != 1 || rec_trace[3] != 1 || rec_trace[4] != -1) begin
      errors++; $display("FAIL vc1_back_to_back trace size %0d exp pops at steps 2..4", rec_trace.size());
    end
    if (idle !== 1'b1) begin errors++; $display("FAIL vc1_final_idle got %b exp 1", idle); end
  endtask

  task automatic test_pause();
    int et[8] = '{-1, 0, -1, -1, -1, 0, 0, 0};
    apply_reset();
    load_weights(3'd3, 3'd1);
    clear_rec();
    for (int i = 0; i < 6; i++) push(0, DW'(i + 1));
    for (int s = 0; s < 12; s++) begin
      pause_out = (s >= 2 && s < 5);
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL pause_step %0d got %b exp %b", step_no, obs, expv); end
    end
    pause_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rec_trace[i] != et[i]) begin errors++; $display("FAIL pause_trace[%0d] got %0d exp %0d", i, rec_trace[i], et[i]); end
    end
    checks++;
    if (rec_data.size() < 1 || rec_data[0] !== 4'd1) begin errors++; $display("FAIL pause_inflight got n=%0d exp word 1", rec_data.size()); end
  endtask

  task automatic test_weights();
    int eo[10] = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    apply_reset();
    load_weights(3'd0, 3'd3);
    clear_rec();
    for (int i = 0; i < 4; i++) push(0, DW'(i));
    for (int i = 0; i < 6; i++) push(1, DW'(8 + i));
    for (int s = 0; s < 16; s++) begin
      init = (s == 3); weight_vc0 = 3'd0; weight_vc1 = 3'd1;
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL wt_step %0d got %b exp %b", step_no, obs, expv); end
    end
    init = 1'b0;
    checks++;
    if (rec_pop.size() != 10) begin errors++; $display("FAIL wt_pop_count got %0d exp 10", rec_pop.size()); end
    for (int i = 0; i < 10 && i < rec_pop.size(); i++) begin
      checks++;
      if (rec_pop[i] != eo[i]) begin errors++; $display("FAIL wt_order[%0d] got %0d exp %0d", i, rec_pop[i], eo[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    load_weights(3'd4, 3'd1);
    for (int i = 0; i < 6; i++) push(0, DW'(i));
    repeat (3) begin
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL rmb_step %0d got %b exp %b", step_no, obs, expv); end
    end
    #2;
    checks += 2;
    if (pop_vc0 !== 1'b1) begin errors++; $display("FAIL rmb_pre_pop got %b exp 1", pop_vc0); end
    if (valid_out !== 1'b1) begin errors++; $display("FAIL rmb_pre_valid got %b exp 1", valid_out); end
    reset_L = 1'b0;
    #1;
    checks += 3;
    if (pop_vc0 !== 1'b0) begin errors++; $display("FAIL rmb_pop0 got %b exp 0", pop_vc0); end
    if (pop_vc1 !== 1'b0) begin errors++; $display("FAIL rmb_pop1 got %b exp 0", pop_vc1); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL rmb_valid got %b exp 0", valid_out); end
    @(posedge clk); #1;
    valid_vc0 = 1'b0; valid_vc1 = 1'b0;
    @(posedge clk); #1;
    reset_L = 1'b1;
    model_reset();
    clear_rec();
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL rmb_idle got %b exp 1", idle); end
    push(1, 4'd9); push(1, 4'd10);
    repeat (14) begin
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL rmb_post_step %0d got %b exp %b", step_no, obs, expv); end
    end
    checks++;
    if (rec_pop.size() < 1 || rec_pop[0] != 0) begin errors++; $display("FAIL rmb_first_tie got n=%0d exp VC0 first", rec_pop.size()); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int s = 0; s < 800; s++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 8) push(0, DW'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 8) push(1, DW'($urandom));
      pause_out  = ($urandom_range(0, 4) == 0);
      init       = ($urandom_range(0, 19) == 0);
      weight_vc0 = WW'($urandom_range(0, 7));
      weight_vc1 = WW'($urandom_range(0, 7));
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL rand_step %0d got %b exp %b", step_no, obs, expv); end
    end
    init = 1'b0; pause_out = 1'b0;
  endtask

`ifdef VC_SCHED_STATS_EN
  task automatic test_stats();
    int   guard;
    logic [7:0] c1_before;
    apply_reset();
    checks += 2;
    if (grant_cnt_vc0 !== 8'd0) begin errors++; $display("FAIL st_rst0 got %0d exp 0", grant_cnt_vc0); end
    if (grant_cnt_vc1 !== 8'd0) begin errors++; $display("FAIL st_rst1 got %0d exp 0", grant_cnt_vc1); end
    load_weights(3'd7, 3'd1);
    c1_before = grant_cnt_vc1;
    for (int i = 0; i < 300; i++) push(0, DW'(i));
    guard = 0;
    while ((q0.size() > 0 || m_owner >= 0) && guard < 400) begin
      step(); checks++; guard++;
      if (obs !== expv) begin errors++; $display("FAIL st_step %0d got %b exp %b", step_no, obs, expv); end
    end
    checks += 4;
    if (guard >= 400) begin errors++; $display("FAIL st_timeout got %0d steps exp < 400", guard); end
    if (grant_cnt_vc0 !== 8'd255) begin errors++; $display("FAIL st_sat0 got %0d exp 255", grant_cnt_vc0); end
    if (grant_cnt_vc0 !== 8'(m_cnt[0])) begin errors++; $display("FAIL st_model0 got %0d exp %0d", grant_cnt_vc0, m_cnt[0]); end
    if (grant_cnt_vc1 !== c1_before) begin errors++; $display("FAIL st_vc1 got %0d exp %0d", grant_cnt_vc1, c1_before); end
    load_weights(3'd1, 3'd1);
    #1;
    checks += 2;
    if (grant_cnt_vc0 !== 8'd0) begin errors++; $display("FAIL st_clr0 got %0d exp 0", grant_cnt_vc0); end
    if (grant_cnt_vc1 !== 8'd0) begin errors++; $display("FAIL st_clr1 got %0d exp 0", grant_cnt_vc1); end
  endtask
`endif

  initial begin
    reset_L = 1'b0; init = 1'b0; pause_out = 1'b0;
    weight_vc0 = '0; weight_vc1 = '0;
    empty_vc0 = 1'b1; empty_vc1 = 1'b1;
    valid_vc0 = 1'b0; valid_vc1 = 1'b0;
    data_vc0 = '0; data_vc1 = '0;
    model_reset();
    test_reset();
    test_wrr_2_1();
    test_vc1_only();
    test_pause();
    test_weights();
    test_reset_mid_burst();
    test_random();
`ifdef VC_SCHED_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
